pattern_tx: RTL and testbench

Serial pattern transmitter: the sending end of the serial single-bit `j` line consumed by the team's `10110` sequence detectors. On a `start` request it shifts a parameterized bit pattern out MSB-first, once per repetition, for a latched repetition count. Optional idle gap cycles separate repetitions. It marks the final bit of each pattern with `expect`, so a bench or a self-test wrapper can compare the marker directly against detector outputs.

---
 rtl/pattern_tx_if.sv | 27 ++
 rtl/pattern_tx.sv | 135 +++++++++++++
 tb/tb_pattern_tx.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pattern_tx_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pattern_tx_if : request/serial-output bundle for pattern_tx
// Revision      : 1.0
// ---------------------------------------------------------------------------
interface pattern_tx_if #(
  parameter int CW = 4
);
  logic          start;
  logic [CW-1:0] count;
  logic          j;
  logic          valid;
  logic          expect_flag;  // "expect" is a reserved word in SystemVerilog
  logic          busy;
  logic          done;

  modport master (
    output start, count,
    input  j, valid, expect_flag, busy, done
  );

  modport slave (
    input  start, count,
    output j, valid, expect_flag, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/pattern_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pattern_tx : repeats a fixed bit pattern MSB-first on j, with idle gaps
// Revision   : 1.0
// ---------------------------------------------------------------------------
module pattern_tx #(
  parameter int               WIDTH   = 5,
  parameter logic [WIDTH-1:0] PATTERN = 5'b10110,
  parameter int               GAP     = 1,
  parameter int               CW      = 4
) (
  input  logic        clk,
  input  logic        rst,
  pattern_tx_if.slave bus
);

  localparam int c_iw = $clog2(WIDTH);
  localparam int c_gw = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [c_iw-1:0] c_idx_top  = c_iw'(WIDTH - 1);
  localparam logic [c_gw-1:0] c_gap_load = (GAP > 0) ? c_gw'(GAP - 1) : '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [c_iw-1:0] r_idx;
  logic [CW-1:0]   r_remaining;
  logic [c_gw-1:0] r_gap_cnt;
  logic            r_j;
  logic            r_valid;
  logic            r_expect;
  logic            r_busy;
  logic            r_done;

  logic [c_iw-1:0] w_idx_dec;
  assign w_idx_dec = r_idx - c_iw'(1);

  // Outputs are computed for the cycle that follows each edge, so r_idx
  // always names the bit currently being driven on j.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_remaining <= '0;
      r_gap_cnt   <= '0;
      r_j         <= 1'b0;
      r_valid     <= 1'b0;
      r_expect    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_remaining <= bus.count;
            if (bus.count != '0) begin
              r_state  <= S_SEND;
              r_idx    <= c_idx_top;
              r_j      <= PATTERN[WIDTH-1];
              r_valid  <= 1'b1;
              r_expect <= 1'b0;
              r_busy   <= 1'b1;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end

        S_SEND: begin
          if (r_idx != '0) begin
            r_idx    <= w_idx_dec;
            r_j      <= PATTERN[w_idx_dec];
            r_expect <= (w_idx_dec == '0);
          end else if (r_remaining == CW'(1)) begin
            r_state  <= S_DONE;
            r_j      <= 1'b0;
            r_valid  <= 1'b0;
            r_expect <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end else begin
            r_remaining <= r_remaining - CW'(1);
            r_idx       <= c_idx_top;
            r_expect    <= 1'b0;
            if (GAP > 0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= c_gap_load;
              r_j       <= 1'b0;
              r_valid   <= 1'b0;
            end else begin
              r_j <= PATTERN[WIDTH-1];
            end
          end
        end

        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state <= S_SEND;
            r_j     <= PATTERN[WIDTH-1];
            r_valid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - c_gw'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end

        default: begin
          r_state  <= S_IDLE;
          r_j      <= 1'b0;
          r_valid  <= 1'b0;
          r_expect <= 1'b0;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.j           = r_j;
  assign bus.valid       = r_valid;
  assign bus.expect_flag = r_expect;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pattern_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pattern_tx : drives GAP=1 and GAP=0 instances side by side against a
//                 cycle-indexed reference model and a 10110 detector model
// Revision      : 1.0
// ---------------------------------------------------------------------------
module tb_pattern_tx;

  localparam int         W   = 5;
  localparam logic [4:0] PAT = 5'b10110;

  logic clk;
  logic rst;

  pattern_tx_if #(.CW(4)) bus1 ();
  pattern_tx_if #(.CW(4)) bus0 ();

  pattern_tx #(.WIDTH(W), .PATTERN(PAT), .GAP(1), .CW(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  pattern_tx #(.WIDTH(W), .PATTERN(PAT), .GAP(0), .CW(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3:0] hist;       // last four j bits seen by the detector model
  logic       moore_q;
  logic       prev_exp;

  typedef struct {
    int cnt;
    bit noise;
    int busy1;
    int busy0;
    int pulses;
  } vec_t;

  vec_t vecs[5];

  // Packed record order: {j, valid, expect, busy, done}
  function automatic logic [4:0] model(int cnt, int gap, int i);
    logic [4:0] pat;
    int         last;
    int         p;
    int         b;
    pat = PAT;
    if (cnt == 0) return (i == 0) ? 5'b00001 : 5'b00000;
    last = cnt * W + (cnt - 1) * gap;
    if (i < last) begin
      p = i % (W + gap);
      if (p < W) begin
        b = W - 1 - p;
        return {pat[b], 1'b1, (b == 0), 1'b1, 1'b0};
      end
      return 5'b00010;
    end
    if (i == last) return 5'b00001;
    return 5'b00000;
  endfunction

  function automatic int last_idx(int cnt, int gap);
    return (cnt == 0) ? 0 : cnt * W + (cnt - 1) * gap;
  endfunction

  task automatic check(input logic [4:0] got, input logic [4:0] exp, input string name);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b required=%b", name, got, exp);
    end
  endtask

  task automatic check_int(input int got, input int exp, input string name);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got=%0d required=%0d", name, got, exp);
    end
  endtask

  function automatic logic [4:0] outs1();
    return {bus1.j, bus1.valid, bus1.expect_flag, bus1.busy, bus1.done};
  endfunction

  function automatic logic [4:0] outs0();
    return {bus0.j, bus0.valid, bus0.expect_flag, bus0.busy, bus0.done};
  endfunction

  // Detector loopback on the back-to-back instance, sampled once per cycle.
  task automatic loopback(input string tag);
    logic mealy;
    mealy = ({hist, bus0.j} == 5'b10110);
    check({4'b0, mealy}, {4'b0, bus0.expect_flag}, {tag, " mealy"});
    check({4'b0, moore_q}, {4'b0, prev_exp}, {tag, " moore"});
    moore_q  = mealy;
    prev_exp = bus0.expect_flag;
    hist     = {hist[2:0], bus0.j};
  endtask

  // Called at a negedge with both instances idle; returns measured busy
  // lengths and expect pulse counts.
  task automatic run_tx(input int cnt, input bit noise, input string tag,
                        output int b1, output int b0, output int e1, output int e0);
    logic [4:0] x1;
    logic [4:0] x0;
    int         stop;
    b1 = 0; b0 = 0; e1 = 0; e0 = 0;
    stop = (last_idx(cnt, 1) > last_idx(cnt, 0)) ? last_idx(cnt, 1) : last_idx(cnt, 0);
    bus1.start = 1'b1; bus1.count = 4'(cnt);
    bus0.start = 1'b1; bus0.count = 4'(cnt);
    for (int i = 0; i <= stop + 1; i++) begin
      @(negedge clk);
      x1 = model(cnt, 1, i);
      x0 = model(cnt, 0, i);
      check(outs1(), x1, $sformatf("%s gap1 cyc%0d", tag, i));
      check(outs0(), x0, $sformatf("%s gap0 cyc%0d", tag, i));
      loopback($sformatf("%s cyc%0d", tag, i));
      b1 += int'(bus1.busy);        b0 += int'(bus0.busy);
      e1 += int'(bus1.expect_flag); e0 += int'(bus0.expect_flag);
      bus1.start = (noise && x1[1]) ? 1'($urandom) : 1'b0;
      bus0.start = (noise && x0[1]) ? 1'($urandom) : 1'b0;
      if (noise) begin
        bus1.count = 4'($urandom);
        bus0.count = 4'($urandom);
      end
    end
    bus1.start = 1'b0;
    bus0.start = 1'b0;
  endtask

  initial begin
    int b1, b0, e1, e0;

    vecs[0] = '{cnt: 1, noise: 1'b0, busy1: 5,  busy0: 5,  pulses: 1};
    vecs[1] = '{cnt: 2, noise: 1'b0, busy1: 11, busy0: 10, pulses: 2};
    vecs[2] = '{cnt: 0, noise: 1'b1, busy1: 0,  busy0: 0,  pulses: 0};
    vecs[3] = '{cnt: 3, noise: 1'b1, busy1: 17, busy0: 15, pulses: 3};
    vecs[4] = '{cnt: 4, noise: 1'b0, busy1: 23, busy0: 20, pulses: 4};

    hist = '0; moore_q = 1'b0; prev_exp = 1'b0;
    rst = 1'b0;
    bus1.start = 1'b0; bus1.count = '0;
    bus0.start = 1'b0; bus0.count = '0;

    #1;
    check(outs1(), 5'b0, "reset gap1");
    check(outs0(), 5'b0, "reset gap0");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      run_tx(vecs[k].cnt, vecs[k].noise, $sformatf("vec%0d", k), b1, b0, e1, e0);
      check_int(b1, vecs[k].busy1,  $sformatf("vec%0d busy gap1", k));
      check_int(b0, vecs[k].busy0,  $sformatf("vec%0d busy gap0", k));
      check_int(e1, vecs[k].pulses, $sformatf("vec%0d expect gap1", k));
      check_int(e0, vecs[k].pulses, $sformatf("vec%0d expect gap0", k));
    end

    // Abort during the third bit of a count=3 run, asynchronously.
    bus1.start = 1'b1; bus1.count = 4'd3;
    bus0.start = 1'b1; bus0.count = 4'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(outs1(), model(3, 1, i), $sformatf("abort gap1 cyc%0d", i));
      check(outs0(), model(3, 0, i), $sformatf("abort gap0 cyc%0d", i));
      bus1.start = 1'b0; bus0.start = 1'b0;
    end
    #2 rst = 1'b0;
    #1;
    check(outs1(), 5'b0, "async reset gap1");
    check(outs0(), 5'b0, "async reset gap0");
    hist = '0; moore_q = 1'b0; prev_exp = 1'b0;
    @(negedge clk);
    check(outs1(), 5'b0, "held reset gap1");
    rst = 1'b1;
    run_tx(1, 1'b0, "restart", b1, b0, e1, e0);
    check_int(b1, 5, "restart busy gap1");

    for (int r = 0; r < 25; r++) begin
      run_tx(int'($urandom_range(0, 15)), 1'b1, $sformatf("rnd%0d", r), b1, b0, e1, e0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
